serial_comp_nbit: RTL and testbench



---
 rtl/serial_comp_nbit.sv | 119 +++++++++++
 tb/tb_serial_comp_nbit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_comp_nbit.sv
// ============================================================================
//  Module   : serial_comp_nbit
//  Brief    : Bit-serial MSB-first magnitude comparator (signed/unsigned),
//             reporting l/e/g with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_comp_nbit #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             e,
    output logic             g
);

    localparam int              c_IW    = $clog2(WIDTH);
    localparam logic [c_IW-1:0] c_MSB   = c_IW'(WIDTH - 1);
    localparam logic            c_EARLY = (EARLY_EXIT != 0);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_s;
    logic [c_IW-1:0]  r_idx;
    logic             r_dl;
    logic             r_dg;
    logic             r_done;
    logic             r_l;
    logic             r_e;
    logic             r_g;

    logic w_bit_a;
    logic w_bit_b;
    logic w_inv;
    logic w_open;
    logic w_set_l;
    logic w_set_g;
    logic w_dl;
    logic w_dg;
    logic w_resolve;

    assign w_bit_a = r_a[r_idx];
    assign w_bit_b = r_b[r_idx];
    // The sign bit carries negative weight in two's complement, so its verdict flips.
    assign w_inv   = r_s && (r_idx == c_MSB);
    assign w_open  = !r_dl && !r_dg;
    assign w_set_g = w_open && (w_inv ? (!w_bit_a && w_bit_b) : (w_bit_a && !w_bit_b));
    assign w_set_l = w_open && (w_inv ? (w_bit_a && !w_bit_b) : (!w_bit_a && w_bit_b));
    assign w_dl    = r_dl | w_set_l;
    assign w_dg    = r_dg | w_set_g;
    assign w_resolve = (r_idx == '0) || (c_EARLY && (w_set_l || w_set_g));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= 1'b0;
            r_idx   <= '0;
            r_dl    <= 1'b0;
            r_dg    <= 1'b0;
            r_done  <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b0;
            r_g     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_s     <= signed_mode;
                        r_idx   <= c_MSB;
                        r_dl    <= 1'b0;
                        r_dg    <= 1'b0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_dl <= w_dl;
                    r_dg <= w_dg;
                    if (w_resolve) begin
                        r_l     <= w_dl;
                        r_g     <= w_dg;
                        r_e     <= !(w_dl || w_dg);
                        r_done  <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy = (r_state == c_RUN);
    assign done = r_done;
    assign l    = r_l;
    assign e    = r_e;
    assign g    = r_g;

endmodule

`default_nettype wire

// File: tb/tb_serial_comp_nbit.sv
// ============================================================================
//  Module   : tb_serial_comp_nbit
//  Brief    : Directed bench for serial_comp_nbit with EARLY_EXIT=0 and =1 instances.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_comp_nbit;

    localparam int c_W = 8;
    localparam logic [2:0] c_L = 3'b100;
    localparam logic [2:0] c_E = 3'b010;
    localparam logic [2:0] c_G = 3'b001;

    typedef struct {
        string      tag;
        logic [2:0] lge;
        int         lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     start_v = 2'b00;
    logic [c_W-1:0] a = '0;
    logic [c_W-1:0] b = '0;
    logic           signed_mode = 1'b0;
    logic [1:0]     busy_v, done_v, l_v, e_v, g_v;

    exp_t       q [2][$];
    logic [2:0] last_lge [2];
    int         n_assert = 0;
    int         n_fail = 0;

    // index 0: EARLY_EXIT=0, index 1: EARLY_EXIT=1
    serial_comp_nbit #(.WIDTH(c_W), .EARLY_EXIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy_v[0]), .done(done_v[0]),
        .l(l_v[0]), .e(e_v[0]), .g(g_v[0])
    );

    serial_comp_nbit #(.WIDTH(c_W), .EARLY_EXIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a), .b(b),
        .signed_mode(signed_mode), .busy(busy_v[1]), .done(done_v[1]),
        .l(l_v[1]), .e(e_v[1]), .g(g_v[1])
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] lge_of(int s);
        return {l_v[s], e_v[s], g_v[s]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge (edge k) accepts the start.
    task automatic drive_start(input int s, input logic [c_W-1:0] av, input logic [c_W-1:0] bv,
                               input logic sm, input logic [2:0] lge, input int lat, input string tag);
        exp_t x;
        a = av; b = bv; signed_mode = sm;
        start_v[s] = 1'b1;
        x.tag = tag; x.lge = lge; x.lat = lat;
        q[s].push_back(x);
        @(negedge clk);
        start_v[s] = 1'b0;
    endtask

    // n0 = number of edges after k already elapsed; returns at the negedge of the done cycle.
    task automatic wait_done(input int s, input int n0);
        exp_t x;
        int   n;
        bit   seen;
        n = n0;
        seen = 0;
        x = q[s].pop_front();
        while (!seen && n < c_W + 4) begin
            n++;
            @(negedge clk);
            if (done_v[s] === 1'b1) begin
                seen = 1;
                chk({x.tag, "_lge"}, 32'(lge_of(s)), 32'(x.lge));
                chk({x.tag, "_lat"}, n, x.lat);
                chk({x.tag, "_busy_off"}, 32'(busy_v[s]), 32'd0);
                last_lge[s] = x.lge;
            end else begin
                if (lge_of(s) !== last_lge[s])
                    chk({x.tag, "_hold"}, 32'(lge_of(s)), 32'(last_lge[s]));
                if (busy_v[s] !== 1'b1)
                    chk({x.tag, "_busy_on"}, 32'(busy_v[s]), 32'd1);
            end
        end
        if (!seen) chk({x.tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        exp_t dummy;
        last_lge[0] = 3'b000;
        last_lge[1] = 3'b000;

        // Reset state
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_lge", 32'(lge_of(s)), 32'd0);
            chk("rst_busy_done", 32'({busy_v[s], done_v[s]}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned MSB difference, plus done lasting a single cycle
        drive_start(1, 8'h80, 8'h7F, 1'b0, c_G, 1, "u_msb");
        wait_done(1, 0);
        @(negedge clk);
        chk("u_msb_done_clear", 32'(done_v[1]), 32'd0);

        // Equal operands on both settings; no early exit on MSB difference
        drive_start(1, 8'h5A, 8'h5A, 1'b0, c_E, 8, "eq_ee1");
        wait_done(1, 0);
        drive_start(0, 8'h5A, 8'h5A, 1'b0, c_E, 8, "eq_ee0");
        wait_done(0, 0);
        drive_start(0, 8'h80, 8'h00, 1'b0, c_G, 8, "noexit_g");
        wait_done(0, 0);

        // Signed mode
        drive_start(1, 8'h80, 8'h01, 1'b1, c_L, 1, "s_neg");
        wait_done(1, 0);
        drive_start(1, 8'h80, 8'h01, 1'b0, c_G, 1, "u_same");
        wait_done(1, 0);
        drive_start(1, 8'hFF, 8'hFE, 1'b1, c_G, 8, "s_lsb");
        wait_done(1, 0);
        drive_start(1, 8'h7F, 8'hFF, 1'b1, c_G, 1, "s_pos_neg");
        wait_done(1, 0);

        // Handshake: ignored start, late operand change, back-to-back run
        drive_start(1, 8'h03, 8'h05, 1'b0, c_L, 6, "hs_first");
        @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        a = 8'h07;
        wait_done(1, 2);
        a = 8'h00; b = 8'h00;
        drive_start(1, 8'h00, 8'h00, 1'b0, c_E, 8, "hs_chain");
        wait_done(1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hs_no_extra_done", 32'(done_v[1]), 32'd0);
        end

        // Reset mid-run on the EARLY_EXIT=0 instance
        drive_start(0, 8'h01, 8'h02, 1'b0, c_L, 8, "abort");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("midrst_lge", 32'(lge_of(s)), 32'd0);
            chk("midrst_busy_done", 32'({busy_v[s], done_v[s]}), 32'd0);
        end
        dummy = q[0].pop_front();
        last_lge[0] = 3'b000;
        last_lge[1] = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done_v[0]), 32'd0);
        end
        drive_start(0, 8'h01, 8'h02, 1'b0, c_L, 8, "after_rst");
        wait_done(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
